// File: rtl/hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_unit_pkg
// Shared pipeline definitions for the hazard unit:
//   - hazard_state_e : FSM state enumeration (RUN / STALL / FLUSH)
//   - HZ_CNT_W       : width of the stall/flush down-counter (covers 1..8)
//   - HZ_REG_W       : register-index width
//   - load_use_hazard: load-use detection between ID and ID/EX
// -----------------------------------------------------------------------------
package hazard_unit_pkg;

  localparam int HZ_CNT_W = $clog2(9);
  localparam int HZ_REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hazard_state_e;

  // A load in EX whose destination is read by the ID instruction; x0 never
  // creates a dependency because it is hard-wired to zero.
  function automatic logic load_use_hazard(
    input logic                mem_read,
    input logic [HZ_REG_W-1:0] ex_rd,
    input logic [HZ_REG_W-1:0] id_rs1,
    input logic [HZ_REG_W-1:0] id_rs2,
    input logic                uses_rs2
  );
    logic hit_s;
    hit_s = (ex_rd == id_rs1) || (uses_rs2 && (ex_rd == id_rs2));
    return mem_read && (ex_rd != {HZ_REG_W{1'b0}}) && hit_s;
  endfunction

endpackage

// File: rtl/hazard_stats.sv
// -----------------------------------------------------------------------------
// hazard_stats
// Saturating event counters for the hazard unit (built only when
// HAZARD_STATS_EN is defined).
//   clk, reset          : clock, synchronous active-high reset (clears counts)
//   stall_i             : PC held this cycle
//   branch_i            : taken branch this cycle
//   stall_cycles_o [32] : number of cycles with the PC held
//   flush_events_o [32] : number of taken branches
// -----------------------------------------------------------------------------
module hazard_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        branch_i,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_events_o
);

  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  // Next-count logic: increment on event, stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (branch_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_events_o = flush_cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Load-use stall and taken-branch flush control for a 5-stage pipeline.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
// Parameters:
//   LOAD_STALL_CYCLES   : cycles ID is held per load-use hazard (1..8)
//   BRANCH_FLUSH_CYCLES : cycles IF/ID and ID/EX are flushed per branch (1..8)
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   ID_RS1, ID_RS2 [5]    : source registers of the ID instruction
//   ID_UsesRS2            : ID instruction reads rs2
//   EX_RD [5], EX_MemRead : destination / load flag of the ID/EX instruction
//   BranchTaken           : branch resolved taken this cycle
//   PCWrite, IF_ID_Write  : PC / IF/ID load enables
//   ID_EX_Bubble          : zero ID/EX control fields
//   IF_ID_Flush           : IF/ID loads a NOP
//   ID_EX_Flush           : ID/EX loads all zeros
//   StallCycles, FlushEvents [32] (HAZARD_STATS_EN only) : statistics
// Outputs are combinational from the FSM state and the current inputs so a
// hazard or branch acts in the cycle it is seen.
// -----------------------------------------------------------------------------
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [HZ_REG_W-1:0] ID_RS1,
  input  logic [HZ_REG_W-1:0] ID_RS2,
  input  logic                ID_UsesRS2,
  input  logic [HZ_REG_W-1:0] EX_RD,
  input  logic                EX_MemRead,
  input  logic                BranchTaken,
  output logic                PCWrite,
  output logic                IF_ID_Write,
  output logic                ID_EX_Bubble,
  output logic                IF_ID_Flush,
  output logic                ID_EX_Flush
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]         StallCycles,
  output logic [31:0]         FlushEvents
`endif
);

  // Counter reload values: the first stall/flush cycle happens in RUN, so
  // the counter only covers the remaining cycles.
  localparam logic [HZ_CNT_W-1:0] STALL_RELOAD = HZ_CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [HZ_CNT_W-1:0] FLUSH_RELOAD = HZ_CNT_W'(BRANCH_FLUSH_CYCLES - 1);
  localparam logic [HZ_CNT_W-1:0] CNT_ZERO     = {HZ_CNT_W{1'b0}};
  localparam logic [HZ_CNT_W-1:0] CNT_ONE      = {{(HZ_CNT_W-1){1'b0}}, 1'b1};

  hazard_state_e             state_d, state_q;
  logic [HZ_CNT_W-1:0]       cnt_d, cnt_q;
  logic                      hazard_s;

  // Next-state, counter and output decode.
  always_comb begin
    hazard_s     = load_use_hazard(EX_MemRead, EX_RD, ID_RS1, ID_RS2, ID_UsesRS2);
    state_d      = state_q;
    cnt_d        = cnt_q;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;

    if (BranchTaken) begin
      // Branch wins over any hazard and aborts a stall; the PC keeps moving
      // so a flush is never paired with a held PC.
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      if (BRANCH_FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        cnt_d   = FLUSH_RELOAD;
      end else begin
        state_d = ST_RUN;
        cnt_d   = CNT_ZERO;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard_s) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = ST_STALL;
              cnt_d   = STALL_RELOAD;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_STALL: begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q - CNT_ONE;
          end
        end
        ST_FLUSH: begin
          // Hazards are ignored: the instructions involved are being flushed.
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  hazard_stats u_stats (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (~PCWrite),
    .branch_i       (BranchTaken),
    .stall_cycles_o (StallCycles),
    .flush_events_o (FlushEvents)
  );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Two instances (LOAD_STALL_CYCLES/BRANCH_FLUSH_CYCLES = 3/4 and 1/1) share the
// same inputs. A reference model tracks "stall cycles left" and "flush cycles
// left" per instance and predicts the five control outputs every cycle.
// Directed sequences pin the model with literal expectations, then random
// traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int LS_A = 3, BF_A = 4;
  localparam int LS_B = 1, BF_B = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_memread, branch_taken;

  logic pcw_a, ifw_a, bub_a, iff_a, exf_a;
  logic pcw_b, ifw_b, bub_b, iff_b, exf_b;
  logic [4:0] vec_a, vec_b;
`ifdef HAZARD_STATS_EN
  logic [31:0] stc_a, fle_a, stc_b, fle_b;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_unit #(.LOAD_STALL_CYCLES(LS_A), .BRANCH_FLUSH_CYCLES(BF_A)) dut_a (
    .clk(clk), .reset(reset), .ID_RS1(id_rs1), .ID_RS2(id_rs2),
    .ID_UsesRS2(id_uses_rs2), .EX_RD(ex_rd), .EX_MemRead(ex_memread),
    .BranchTaken(branch_taken), .PCWrite(pcw_a), .IF_ID_Write(ifw_a),
    .ID_EX_Bubble(bub_a), .IF_ID_Flush(iff_a), .ID_EX_Flush(exf_a)
`ifdef HAZARD_STATS_EN
    , .StallCycles(stc_a), .FlushEvents(fle_a)
`endif
  );

  hazard_unit #(.LOAD_STALL_CYCLES(LS_B), .BRANCH_FLUSH_CYCLES(BF_B)) dut_b (
    .clk(clk), .reset(reset), .ID_RS1(id_rs1), .ID_RS2(id_rs2),
    .ID_UsesRS2(id_uses_rs2), .EX_RD(ex_rd), .EX_MemRead(ex_memread),
    .BranchTaken(branch_taken), .PCWrite(pcw_b), .IF_ID_Write(ifw_b),
    .ID_EX_Bubble(bub_b), .IF_ID_Flush(iff_b), .ID_EX_Flush(exf_b)
`ifdef HAZARD_STATS_EN
    , .StallCycles(stc_b), .FlushEvents(fle_b)
`endif
  );

  // Output vector order: {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush}
  assign vec_a = {pcw_a, ifw_a, bub_a, iff_a, exf_a};
  assign vec_b = {pcw_b, ifw_b, bub_b, iff_b, exf_b};

  localparam logic [4:0] V_RUN   = 5'b11000;
  localparam logic [4:0] V_STALL = 5'b00100;
  localparam logic [4:0] V_FLUSH = 5'b11011;

  // ---------------- reference model ----------------
  int          ls_p [2] = '{LS_A, LS_B};
  int          bf_p [2] = '{BF_A, BF_B};
  int          stall_left [2];
  int          flush_left [2];
  int unsigned stall_cnt [2];
  int unsigned flush_cnt [2];
  bit          model_valid = 1'b0;

  function automatic bit hazard_now();
    return ex_memread && (ex_rd != 5'd0) &&
           ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  endfunction

  function automatic logic [4:0] expect_vec(input int k);
    if (branch_taken)       return V_FLUSH;
    if (flush_left[k] > 0)  return V_FLUSH;
    if (stall_left[k] > 0)  return V_STALL;
    if (hazard_now())       return V_STALL;
    return V_RUN;
  endfunction

  // Model update at each active edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        stall_left[k] <= 0;
        flush_left[k] <= 0;
        stall_cnt[k]  <= 0;
        flush_cnt[k]  <= 0;
      end else begin
        stall_cnt[k] <= stall_cnt[k] + ((expect_vec(k) == V_STALL) ? 1 : 0);
        flush_cnt[k] <= flush_cnt[k] + (branch_taken ? 1 : 0);
        if (branch_taken) begin
          flush_left[k] <= bf_p[k] - 1;
          stall_left[k] <= 0;
        end else if (flush_left[k] > 0) begin
          flush_left[k] <= flush_left[k] - 1;
        end else if (stall_left[k] > 0) begin
          stall_left[k] <= stall_left[k] - 1;
        end else if (hazard_now()) begin
          stall_left[k] <= ls_p[k] - 1;
        end
      end
    end
    if (reset) model_valid <= 1'b1;
  end

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_a", vec_a, expect_vec(0));
      chk("model_b", vec_b, expect_vec(1));
`ifdef HAZARD_STATS_EN
      chk32("stall_cnt_a", stc_a, stall_cnt[0]);
      chk32("flush_cnt_a", fle_a, flush_cnt[0]);
      chk32("stall_cnt_b", stc_b, stall_cnt[1]);
      chk32("flush_cnt_b", fle_b, flush_cnt[1]);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic uses, input logic br);
    ex_memread = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs2 = uses; branch_taken = br;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    adv(); adv();
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("reset_a", vec_a, V_RUN);
    chk("reset_b", vec_b, V_RUN);
    adv();

    // Load-use on rs1: held exactly LOAD_STALL_CYCLES cycles.
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu_a_c0", vec_a, V_STALL);
    chk("lu_b_c0", vec_b, V_STALL);
    adv();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu_a_c1", vec_a, V_STALL);
    chk("lu_b_c1", vec_b, V_RUN);
    adv();
    @(negedge clk);
    chk("lu_a_c2", vec_a, V_STALL);
    adv();
    @(negedge clk);
    chk("lu_a_c3", vec_a, V_RUN);
    adv();

    // x0 destination never stalls.
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("x0_a", vec_a, V_RUN);
    chk("x0_b", vec_b, V_RUN);
    adv();

    // rs2 match only counts when rs2 is used.
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
    @(negedge clk);
    chk("rs2_off_a", vec_a, V_RUN);
    chk("rs2_off_b", vec_b, V_RUN);
    adv();
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
    @(negedge clk);
    chk("rs2_on_a", vec_a, V_STALL);
    chk("rs2_on_b", vec_b, V_STALL);
    adv();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    adv(); adv(); adv();

    // Branch in the second stall cycle aborts the stall and flushes 4 cycles.
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pri_a_c0", vec_a, V_STALL);
    adv();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("pri_a_c1", vec_a, V_FLUSH);
    chk("pri_b_c1", vec_b, V_FLUSH);
    adv();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("pri_a_c2", vec_a, V_FLUSH);
    chk("pri_b_c2", vec_b, V_RUN);
    adv(); adv();
    @(negedge clk);
    chk("pri_a_c4", vec_a, V_FLUSH);
    adv();
    @(negedge clk);
    chk("pri_a_c5", vec_a, V_RUN);
    adv();

    // Reset in the second flush cycle clears the flush.
    branch_taken = 1'b1;
    adv();
    branch_taken = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rstfl_a_c1", vec_a, V_FLUSH);
    adv();
    reset = 1'b0;
    @(negedge clk);
    chk("rstfl_a_c2", vec_a, V_RUN);
    chk("rstfl_b_c2", vec_b, V_RUN);
    adv();

`ifdef HAZARD_STATS_EN
    // Two 1-cycle stalls and one branch on the LOAD_STALL_CYCLES=1 instance.
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0); adv();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); adv(); adv(); adv();
    set_in(1'b1, 5'd6, 5'd0, 5'd6, 1'b1, 1'b0); adv();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); adv();
    branch_taken = 1'b1; adv();
    branch_taken = 1'b0;
    @(negedge clk);
    chk32("stats_b_stalls", stc_b, 32'd2);
    chk32("stats_b_flushes", fle_b, 32'd1);
    adv();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(99) < 2);
      ex_memread   = ($urandom_range(1) == 1);
      ex_rd        = 5'($urandom_range(3));
      id_rs1       = 5'($urandom_range(3));
      id_rs2       = 5'($urandom_range(3));
      id_uses_rs2  = ($urandom_range(1) == 1);
      branch_taken = ($urandom_range(99) < 10);
      adv();
    end
    reset = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    adv(); adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter LOAD_STALL_CYCLES, default 1, meaning cycles ID is held per load-use hazard (legal 1..8).
REQ-002 SHALL have parameter BRANCH_FLUSH_CYCLES, default 1, meaning cycles IF/ID and ID/EX are flushed per taken branch (legal 1..8).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ID_RS1  input  5  rs1 field of the instruction in ID.
REQ-006 SHALL have port ID_RS2  input  5  rs2 field of the instruction in ID.
REQ-007 SHALL have port ID_UsesRS2  input  1  ID instruction reads rs2.
REQ-008 SHALL have port EX_RD  input  5  destination register held in ID/EX.
REQ-009 SHALL have port EX_MemRead  input  1  ID/EX instruction is a load (memory-read bit of ID/EX M field).
REQ-010 SHALL have port BranchTaken  input  1  branch resolved taken this cycle.
REQ-011 SHALL have port PCWrite  output  1  PC may update.
REQ-012 SHALL have port IF_ID_Write  output  1  IF/ID may load.
REQ-013 SHALL have port ID_EX_Bubble  output  1  ID/EX loads zeroed control (WB, M, EX).
REQ-014 SHALL have port IF_ID_Flush  output  1  IF/ID loads a NOP.
REQ-015 SHALL have port ID_EX_Flush  output  1  ID/EX loads all-zero contents.

Function
REQ-016 SHALL compute hazard = EX_MemRead && EX_RD!=0 && (EX_RD==ID_RS1 || (ID_UsesRS2 && EX_RD==ID_RS2)).
REQ-017 SHALL implement FSM states RUN, STALL, FLUSH with a down-counter of width $clog2(9).
REQ-018 SHALL, in RUN with no event, drive PCWrite=1, IF_ID_Write=1, all other outputs 0.
REQ-019 SHALL, in RUN with hazard and no BranchTaken, drive PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 in the same cycle (combinational); if LOAD_STALL_CYCLES>1, go to STALL with counter=LOAD_STALL_CYCLES-1, else stay in RUN.
REQ-020 SHALL, in STALL, hold the REQ-019 outputs, decrement the counter, and return to RUN on the cycle the counter reaches 1.
REQ-021 SHALL, on BranchTaken in any state, drive IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0 that cycle; branch wins over hazard and aborts STALL.
REQ-022 SHALL, after BranchTaken, enter FLUSH with counter=BRANCH_FLUSH_CYCLES-1 if BRANCH_FLUSH_CYCLES>1, else go to RUN.
REQ-023 SHALL, in FLUSH, keep REQ-021 outputs, ignore hazard, decrement counter, return to RUN when it reaches 1; a new BranchTaken in FLUSH reloads the counter.
REQ-024 SHALL never assert PCWrite=0 and IF_ID_Flush=1 in the same cycle.

Reset
REQ-025 SHALL, while reset is high at a clock edge, set state=RUN and counter=0; outputs then equal REQ-018 values.
REQ-026 SHALL, with reset asserted mid-STALL or mid-FLUSH, be in RUN on the following cycle with no residual stall or flush.

Configuration
REQ-027 SHALL, when HAZARD_STATS_EN is defined, add outputs StallCycles (32) and FlushEvents (32): StallCycles increments each cycle PCWrite=0, FlushEvents on each BranchTaken; both saturate at all-ones and clear on reset.
REQ-028 SHALL, when HAZARD_STATS_EN is undefined, omit those ports and counters with no other behavioural change.

Structure
REQ-029 SHALL place the FSM state enumeration and counter width constant in the shared pipeline package.
REQ-030 SHALL be a single module; the optional statistics counters form sub-module hazard_stats.

Verification
REQ-031 SHALL cover load-use: EX_MemRead=1, EX_RD=5, ID_RS1=5 -> PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly LOAD_STALL_CYCLES cycles.
REQ-032 SHALL cover x0: EX_MemRead=1, EX_RD=0, ID_RS1=0 -> no stall.
REQ-033 SHALL cover rs2 gating: EX_RD=7, ID_RS2=7, ID_UsesRS2=0 -> no stall; ID_UsesRS2=1 -> stall.
REQ-034 SHALL cover priority: LOAD_STALL_CYCLES=3, BranchTaken in 2nd stall cycle -> that cycle IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1; stall abandoned.
REQ-035 SHALL cover reset mid-FLUSH (BRANCH_FLUSH_CYCLES=4, reset in 2nd cycle) -> next cycle PCWrite=1, both flush outputs 0.
REQ-036 SHALL cover, with HAZARD_STATS_EN, two 1-cycle stalls and one branch -> StallCycles=2, FlushEvents=1.
